// File: rtl/prom_boot_copier.sv
// prom_boot_copier: bus initiator that copies WORDS words from the PROM window
// at SRC_BASE to RAM at DST_BASE over the stb/we/addr/ack word bus.
// Each word is one read, a one-cycle strobe gap, one write and another gap.
// The gap after every ack keeps a toggling-ack slave from seeing a second access.
// Optional feature macro: PROM_COPY_CHECKSUM_EN adds a running 32-bit sum of
// every word read, exposed on the checksum port.
module prom_boot_copier #(
  parameter logic [21:0] SRC_BASE = 22'h3FFC00,
  parameter logic [21:0] DST_BASE = 22'h000000,
  parameter int unsigned WORDS    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        stb,
  output logic        we,
  output logic [21:0] addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        ack
`ifdef PROM_COPY_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam int unsigned    IW   = $clog2(WORDS + 1);
  localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_GAP,
    S_WR,
    S_WR_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [21:0]   addr_q, addr_d;
  logic [31:0]   data_out_q, data_out_d;
`ifdef PROM_COPY_CHECKSUM_EN
  logic [31:0]   cks_q, cks_d;
`endif

  // Next-state and next-output decode; bus outputs only move when a state is left.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
`ifdef PROM_COPY_CHECKSUM_EN
    cks_d      = cks_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = SRC_BASE;
`ifdef PROM_COPY_CHECKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      S_RD: begin
        if (ack) begin
          state_d    = S_RD_GAP;
          stb_d      = 1'b0;
          data_out_d = data_in;
`ifdef PROM_COPY_CHECKSUM_EN
          cks_d      = cks_q + data_in;
`endif
        end
      end
      S_RD_GAP: begin
        state_d = S_WR;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = DST_BASE + 22'(idx_q);
      end
      S_WR: begin
        if (ack) begin
          state_d = S_WR_GAP;
          stb_d   = 1'b0;
        end
      end
      S_WR_GAP: begin
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_RD;
          idx_d   = idx_q + IW'(1);
          stb_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = SRC_BASE + 22'(idx_q) + 22'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset releases the bus at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_out_q <= '0;
`ifdef PROM_COPY_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
`ifdef PROM_COPY_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign stb      = stb_q;
  assign we       = we_q;
  assign addr     = addr_q;
  assign data_out = data_out_q;
`ifdef PROM_COPY_CHECKSUM_EN
  assign checksum = cks_q;
`endif

endmodule
